// File: rtl/sys_clk_stepper.sv
// sys_clk_stepper: derives the core clock SYS_clk from the 50 MHz board clock.
// In single-step mode a debounced key press gives one pulse; in free-run mode the rate is selectable.
// Ports:
//   SYS_clk_50     - board clock, the only clock of the block
//   SYS_reset_n    - asynchronous active-low reset
//   SYS_step_key   - raw push button, active-low, bouncy
//   SYS_run        - 1 = free-run, 0 = single-step
//   SYS_rate_sel   - free-run half-period select
//   SYS_clk        - generated core clock, straight from a flop
//   SYS_busy       - high whenever the generator is not idle
//   SYS_step_count - SYS_clk rising edges since reset, wraps at 16 bits
module sys_clk_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HIGH_CYCLES     = 25,
  parameter int unsigned HALF_P0         = 25000000,
  parameter int unsigned HALF_P1         = 2500000,
  parameter int unsigned HALF_P2         = 250000,
  parameter int unsigned HALF_P3         = 25000
) (
  input  logic        SYS_clk_50,
  input  logic        SYS_reset_n,
  input  logic        SYS_step_key,
  input  logic        SYS_run,
  input  logic [1:0]  SYS_rate_sel,
  output logic        SYS_clk,
  output logic        SYS_busy,
  output logic [15:0] SYS_step_count
);

  localparam int unsigned MAX01 = (HALF_P0 > HALF_P1) ? HALF_P0 : HALF_P1;
  localparam int unsigned MAX23 = (HALF_P2 > HALF_P3) ? HALF_P2 : HALF_P3;
  localparam int unsigned MAXH  = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned MAXP  = (MAXH > HIGH_CYCLES) ? MAXH : HIGH_CYCLES;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(MAXP + 1);

  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] HI_LAST = PW'(HIGH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP_HI,
    RUN_LO,
    RUN_HI
  } state_t;

  logic          key_m;
  logic          key_s;
  logic          run_m;
  logic          run_s;
  logic [DW-1:0] db_cnt;
  logic          key_lvl;
  logic          key_lvl_d;
  logic          press;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_n;
  logic [PW-1:0] half;
  logic [PW-1:0] half_n;
  logic [PW-1:0] half_sel;
  logic [PW-1:0] half_last;
  logic          clk_n;

  // Key syncs to released (1); run syncs to single-step (0) so
  // nothing starts on its own after reset.
  always_ff @(posedge SYS_clk_50 or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      run_m <= 1'b0;
      run_s <= 1'b0;
    end else begin
      key_m <= SYS_step_key;
      key_s <= key_m;
      run_m <= SYS_run;
      run_s <= run_m;
    end
  end

  always_ff @(posedge SYS_clk_50 or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      db_cnt    <= '0;
      key_lvl   <= 1'b1;
      key_lvl_d <= 1'b1;
    end else begin
      key_lvl_d <= key_lvl;
      if (db_cnt == DB_MAX) begin
        key_lvl <= ~key_lvl;
        db_cnt  <= '0;
      end else if (key_s != key_lvl) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = key_lvl_d & ~key_lvl;

  always_comb begin
    half_sel = PW'(HALF_P0);
    unique case (SYS_rate_sel)
      2'd0: half_sel = PW'(HALF_P0);
      2'd1: half_sel = PW'(HALF_P1);
      2'd2: half_sel = PW'(HALF_P2);
      2'd3: half_sel = PW'(HALF_P3);
      default: half_sel = PW'(HALF_P0);
    endcase
  end

  assign half_last = half - 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    half_n  = half;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (run_s) begin
          state_n = RUN_LO;
          half_n  = half_sel;
        end else if (press) begin
          state_n = STEP_HI;
        end
      end
      STEP_HI: begin
        if (cnt == HI_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN_LO: begin
        if (!run_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == half_last) begin
          state_n = RUN_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN_HI: begin
        // A started high phase always completes.
        if (cnt == half_last) begin
          cnt_n = '0;
          if (run_s) begin
            state_n = RUN_LO;
            half_n  = half_sel;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Clock is registered from the next state so it changes once per edge.
  assign clk_n = (state_n == STEP_HI) || (state_n == RUN_HI);

  always_ff @(posedge SYS_clk_50 or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      half           <= '0;
      SYS_clk        <= 1'b0;
      SYS_step_count <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      half    <= half_n;
      SYS_clk <= clk_n;
      if (clk_n && !SYS_clk) begin
        SYS_step_count <= SYS_step_count + 16'd1;
      end
    end
  end

  assign SYS_busy = (state != IDLE);

endmodule

// File: tb/tb_sys_clk_stepper.sv
// tb_sys_clk_stepper: directed bench for sys_clk_stepper with a phase-level model
// compared every cycle, plus hand-computed timing expectations.
module tb_sys_clk_stepper;

  localparam int D = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  rate = 2'd0;
  logic        SYS_clk;
  logic        SYS_busy;
  logic [15:0] SYS_step_count;

  sys_clk_stepper #(
    .DEBOUNCE_CYCLES(D),
    .HIGH_CYCLES(H),
    .HALF_P0(5),
    .HALF_P1(4),
    .HALF_P2(3),
    .HALF_P3(1)
  ) dut (
    .SYS_clk_50(clk),
    .SYS_reset_n(rst_n),
    .SYS_step_key(key),
    .SYS_run(run),
    .SYS_rate_sel(rate),
    .SYS_clk(SYS_clk),
    .SYS_busy(SYS_busy),
    .SYS_step_count(SYS_step_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: phase 0 idle, 1 step high, 2 run low, 3 run high
  logic         mk1, mk2, mr1, mr2;
  logic         mstab, mstab_d;
  logic [D-1:0] mm_hist;
  int           mphase, mleft, mhalf;
  logic         mclk;
  logic [15:0]  mcnt;

  // observation helpers
  int          cyc = 0;
  int          rise_cyc = 0;
  int          hi_len = 0;
  int          gap = 0;
  int          nrise = 0;
  logic        prev_clk = 1'b0;
  logic [15:0] prev_cnt = 16'd0;
  bit          saw_wrap = 1'b0;

  function automatic int half_of(input logic [1:0] r);
    case (r)
      2'd0: return 5;
      2'd1: return 4;
      2'd2: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mk1 = 1'b1; mk2 = 1'b1; mr1 = 1'b0; mr2 = 1'b0;
    mstab = 1'b1; mstab_d = 1'b1; mm_hist = '0;
    mphase = 0; mleft = 0; mhalf = 0;
    mclk = 1'b0; mcnt = 16'd0;
  endtask

  task automatic model_edge();
    logic press, runs, nclk;
    press = mstab_d & ~mstab;
    runs  = mr2;
    case (mphase)
      0: begin
        if (runs) begin
          mphase = 2; mhalf = half_of(rate); mleft = mhalf;
        end else if (press) begin
          mphase = 1; mleft = H;
        end
      end
      1: begin
        mleft--;
        if (mleft == 0) mphase = 0;
      end
      2: begin
        if (!runs) mphase = 0;
        else begin
          mleft--;
          if (mleft == 0) begin mphase = 3; mleft = mhalf; end
        end
      end
      default: begin
        mleft--;
        if (mleft == 0) begin
          if (runs) begin
            mphase = 2; mhalf = half_of(rate); mleft = mhalf;
          end else mphase = 0;
        end
      end
    endcase
    nclk = (mphase == 1) || (mphase == 3);
    if (nclk && !mclk) mcnt = mcnt + 16'd1;
    mclk = nclk;
    // level flips once the last D samples all disagreed with it
    mstab_d = mstab;
    if (&mm_hist) begin
      mstab = ~mstab; mm_hist = '0;
    end else begin
      mm_hist = {mm_hist[D-2:0], (mk2 != mstab)};
    end
    mk2 = mk1; mk1 = key;
    mr2 = mr1; mr1 = run;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", {14'd0, SYS_clk, SYS_busy, SYS_step_count},
          {14'd0, mclk, (mphase != 0), mcnt});
    if (SYS_clk && !prev_clk) begin
      gap = cyc - rise_cyc;
      rise_cyc = cyc;
      nrise++;
      if (prev_cnt == 16'hFFFF && SYS_step_count == 16'h0000) saw_wrap = 1'b1;
    end
    if (!SYS_clk && prev_clk) hi_len = cyc - rise_cyc;
    prev_clk = SYS_clk;
    prev_cnt = SYS_step_count;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_clk", {31'd0, SYS_clk}, 32'd0);
    check("rst_busy", {31'd0, SYS_busy}, 32'd0);
    check("rst_count", {16'd0, SYS_step_count}, 32'd0);
    model_reset();
    prev_clk = 1'b0;
    prev_cnt = 16'd0;
    run = 1'b0;
    key = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_high2(input string name);
    bit found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (SYS_clk && cyc == rise_cyc + 2) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_level(input string name, input logic lvl);
    bit found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (SYS_clk == lvl) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int r0, first, bad;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset in the middle of a free-run high phase
    run = 1'b1;
    rate = 2'd0;
    repeat (10) step();
    check("pre_reset_high", {31'd0, SYS_clk}, 32'd1);
    do_reset();
    repeat (10) step();
    check("post_rst_clk", {31'd0, SYS_clk}, 32'd0);
    check("post_rst_busy", {31'd0, SYS_busy}, 32'd0);
    check("post_rst_cnt", {16'd0, SYS_step_count}, 32'd0);

    // 2: clean press, rise 7 cycles after the key falls
    key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t2_clk", {31'd0, SYS_clk}, {31'd0, (i >= 7 && i <= 9)});
    end
    key = 1'b1;
    repeat (20) step();
    check("t2_count", {16'd0, SYS_step_count}, 32'd1);

    // 3: bouncy key then a held press
    for (int i = 0; i < 12; i++) begin
      key = ((i / 2) % 2) ? 1'b1 : 1'b0;
      step();
    end
    check("t3_no_bounce_pulse", {16'd0, SYS_step_count}, 32'd1);
    key = 1'b0;
    repeat (20) step();
    key = 1'b1;
    repeat (20) step();
    check("t3_count", {16'd0, SYS_step_count}, 32'd2);
    check("t3_high_len", hi_len, 32'd3);

    // 4: free-run at rate 0, then switch to rate 3 mid high phase
    run = 1'b1;
    rate = 2'd0;
    repeat (100) step();
    check("t4_period", gap, 32'd10);
    check("t4_high_len", hi_len, 32'd5);
    wait_high2("t4_wait_high");
    rate = 2'd3;
    wait_level("t4_wait_fall", 1'b0);
    check("t4_finish_high", hi_len, 32'd5);
    repeat (10) step();
    check("t4_fast_period", gap, 32'd2);
    check("t4_fast_high", hi_len, 32'd1);

    // 5: run drops during a high phase, then during a low phase
    rate = 2'd0;
    repeat (30) step();
    wait_high2("t5_wait_high");
    run = 1'b0;
    wait_level("t5_wait_fall", 1'b0);
    check("t5_full_high", hi_len, 32'd5);
    repeat (3) step();
    check("t5_idle_busy", {31'd0, SYS_busy}, 32'd0);
    check("t5_idle_clk", {31'd0, SYS_clk}, 32'd0);
    run = 1'b1;
    wait_level("t5_wait_rise", 1'b1);
    wait_level("t5_wait_fall2", 1'b0);
    run = 1'b0;
    r0 = nrise;
    repeat (10) step();
    check("t5_no_edge", nrise - r0, 32'd0);
    check("t5_lo_busy", {31'd0, SYS_busy}, 32'd0);

    // 6: fastest free-run long enough to wrap the counter, with presses
    rate = 2'd3;
    run = 1'b1;
    saw_wrap = 1'b0;
    bad = 0;
    first = nrise;
    for (int i = 0; i < 131072; i++) begin
      r0 = nrise;
      key = ((i % 20000) < 20) ? 1'b0 : 1'b1;
      step();
      if (nrise != r0 && nrise > first + 1 && gap != 2) bad++;
    end
    key = 1'b1;
    run = 1'b0;
    repeat (10) step();
    check("t6_wrap_seen", {31'd0, saw_wrap}, 32'd1);
    check("t6_steady_period", bad, 32'd0);
    check("t6_idle", {31'd0, SYS_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
